// File: rtl/ss_adc_sequencer.sv
// Single-slope ADC conversion sequencer: discharge/settle, ramp count, capture on first comparator rise.
// Latency: SETTLE cycles discharge, up to 2^WIDTH ramp cycles, result valid 2 cycles after comparator rise.
// Backpressure: result held in DONE until o_data_ready; start is only accepted in IDLE or with the DONE handshake.
module ss_adc_sequencer #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_cmp,
   output logic             o_ramp_rst,
   output logic             o_ramp_en,
   output logic             o_busy,
   output logic             o_data_valid,
   input  logic             i_data_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_overflow
);

   // Settle counter only has to reach SETTLE-1; keep at least one bit.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_RAMP,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [SW-1:0]    r_settle;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_data;
   logic             r_overflow;
   logic             r_ramp_rst;
   logic             r_ramp_en;
   logic             r_busy;
   logic             r_data_valid;

   logic             r_cmp_n;
   logic             r_cmp_s;
   logic             r_cmp_q;
   logic             w_rise;

   // First comparator sampling stage on the falling edge gives the async input half a cycle to resolve.
   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) r_cmp_n <= 1'b0;
      else       r_cmp_n <= i_cmp;
   end

   // Second sync stage plus a delayed copy for rising-edge detection; runs in every state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cmp_s <= 1'b0;
         r_cmp_q <= 1'b0;
      end else begin
         r_cmp_s <= r_cmp_n;
         r_cmp_q <= r_cmp_s;
      end
   end

   // A comparator already high at ramp start never produces a rise, so that conversion saturates.
   assign w_rise = r_cmp_s & ~r_cmp_q;

   // Conversion FSM with all outputs registered alongside the state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_settle     <= '0;
         r_count      <= '0;
         r_data       <= '0;
         r_overflow   <= 1'b0;
         r_ramp_rst   <= 1'b1;
         r_ramp_en    <= 1'b0;
         r_busy       <= 1'b0;
         r_data_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state  <= S_SETTLE;
                  r_settle <= '0;
                  r_busy   <= 1'b1;
               end
            end
            S_SETTLE: begin
               r_settle <= r_settle + 1'b1;
               if (r_settle == SW'(SETTLE - 1)) begin
                  r_state    <= S_RAMP;
                  r_count    <= '0;
                  r_ramp_en  <= 1'b1;
                  r_ramp_rst <= 1'b0;
               end
            end
            S_RAMP: begin
               r_count <= r_count + 1'b1;
               // Edge wins over saturation when both happen on the last count.
               if (w_rise || (r_count == {WIDTH{1'b1}})) begin
                  r_data       <= w_rise ? r_count : {WIDTH{1'b1}};
                  r_overflow   <= ~w_rise;
                  r_state      <= S_DONE;
                  r_ramp_en    <= 1'b0;
                  r_ramp_rst   <= 1'b1;
                  r_data_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (r_data_valid && i_data_ready) begin
                  r_data_valid <= 1'b0;
                  if (i_start) begin
                     r_state  <= S_SETTLE;
                     r_settle <= '0;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ramp_rst   = r_ramp_rst;
   assign o_ramp_en    = r_ramp_en;
   assign o_busy       = r_busy;
   assign o_data_valid = r_data_valid;
   assign o_data       = r_data;
   assign o_overflow   = r_overflow;

endmodule

// File: doc/ss_adc_sequencer.md
# ss_adc_sequencer

Conversion sequencer for the single-slope (ramp) ADC front end. It discharges and releases the ramp and runs a WIDTH-bit conversion counter. It samples the raw comparator output through a negedge-then-posedge synchroniser and captures the counter value on the comparator's first rising edge. The result is presented on a valid/ready output port. It sits between the analog ramp/comparator macro and the downstream sample consumer (capture FIFO or trace logger).

## Interface
- WIDTH, 8, conversion counter and result width; maximum ramp length is 2^WIDTH cycles.
- SETTLE, 4, cycles the ramp is held in discharge before each conversion; must be at least 1.

- clk  in  1  single system clock; all state updates on posedge except the first comparator sampling flop (negedge).
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- start  in  1  conversion request; sampled only in IDLE, and in DONE during the handshake cycle.
- cmp  in  1  raw asynchronous comparator output; high once ramp exceeds input.
- ramp_rst  out  1  ramp discharge; high in every state except RAMP.
- ramp_en  out  1  ramp/counter run; high only in RAMP.
- busy  out  1  high in every state except IDLE.
- data_valid  out  1  result available; high only in DONE.
- data_ready  in  1  consumer accepts result.
- data  out  WIDTH  captured count; stable while data_valid is high.
- overflow  out  1  set when the counter saturated without a comparator edge; qualifies data.

## Operation
- Outputs are decoded from registered state or are registers only; there is no combinational path from any input to any output.
- Comparator path:
  - cmp_n samples cmp on negedge clk.
  - cmp_s registers cmp_n on posedge.
  - cmp_q registers cmp_s on posedge.
  - rise = cmp_s & ~cmp_q.
  - All three flops update continuously in every state.
  - rise is acted on only in RAMP.
- States: IDLE, SETTLE, RAMP, DONE.
- IDLE:
  - start=1 at posedge: go to SETTLE and clear the settle counter.
  - Otherwise stay in IDLE.
- SETTLE:
  - The settle counter increments each cycle.
  - When the settle counter equals SETTLE-1: go to RAMP and clear the conversion counter to 0.
- RAMP:
  - The count increments by 1 each cycle.
  - rise=1: data<=count (current value, before increment), overflow<=0, go to DONE.
  - Else if count==2^WIDTH-1: data<=all ones, overflow<=1, go to DONE.
  - rise and count==2^WIDTH-1 in the same cycle: the edge wins, so data=all ones and overflow=0.
- DONE:
  - Hold data and overflow.
  - data_valid=1 and data_ready=1: complete the handshake.
  - Handshake with start=1 in that cycle: go to SETTLE (back-to-back conversion).
  - Handshake with start=0: go to IDLE.
- start is ignored in SETTLE and RAMP; requests are not queued.
- If cmp is already high when RAMP is entered, there is no rise. The conversion runs to overflow.
- data and overflow change only at capture. They persist after the handshake until the next capture.

## Timing
- Reset values:
  - state=IDLE
  - ramp_rst=1, ramp_en=0, busy=0
  - data_valid=0, data=0, overflow=0
  - count=0, settle counter=0
  - cmp_n=cmp_s=cmp_q=0
- Reset asserted mid-conversion: the block returns to IDLE asynchronously and any in-flight result is discarded. The first start after deassertion is honoured normally.
- start high at posedge S0 (IDLE):
  - busy and ramp_rst are high from S0.
  - ramp_en rises at S0+SETTLE.
  - The first RAMP cycle has count=0.
- Capture latency:
  - cmp rises before the negedge of a RAMP cycle in which count==N: data=N+1.
  - data_valid rises at the second posedge after that rise.
  - The 2-cycle synchroniser offset is not corrected by the block.
- No edge: overflow capture occurs at the posedge ending the RAMP cycle with count=2^WIDTH-1, so RAMP lasts 2^WIDTH cycles.
- data_valid falls at the posedge where data_valid&data_ready is sampled. Minimum DONE dwell is 1 cycle.
- Back-to-back conversions: the period is SETTLE + RAMP length + DONE dwell cycles.

## Test plan
All scenarios use WIDTH=8 and SETTLE=4.
- Reset: assert rst asynchronously mid-RAMP at count=100 -> state IDLE immediately; ramp_rst=1, ramp_en=0, busy=0, data_valid=0, data=0, overflow=0.
- Normal conversion: start pulse; raise cmp before negedge of the cycle with count=35; data_ready=1 -> ramp_en high 4 cycles after start, data=36, overflow=0, data_valid high exactly 1 cycle, busy drops after the handshake.
- Overflow: start, cmp held 0 -> ramp_en high 256 cycles, data=255, overflow=1, data_valid=1.
- Edge at saturation: cmp timed so rise coincides with count=255 -> data=255, overflow=0.
- Backpressure and back-to-back: data_ready=0 for 10 cycles after capture with data=20 -> data_valid and data hold at 20. start is ignored while busy. Then data_ready=1 with start=1 in the same cycle -> next cycle in SETTLE, data_valid=0.
- cmp stuck high: cmp=1 throughout, start -> no capture on entry to RAMP; overflow=1, data=255.
